serial_rx_fifo_ctl: RTL and testbench
=====================================

# serial_rx_fifo_ctl

Parametrised UART receiver. It generalises the fixed 8N1 serial receiver to:
- configurable baud divisor, data width, parity and stop bits;
- input synchroniser and 3-sample majority voting;
- per-word parity and framing error flags;
- an output FIFO with valid/ready handshake.

It sits between the board RX pin and any consumer (command parser, BG loader) that cannot accept a byte on the exact cycle it completes.

## Interface
- `CLK_FREQ`, 27_000_000: system clock in Hz.
- `BAUD`, 115200: line rate. `DIV = CLK_FREQ/BAUD`, integer-truncated (234 at defaults). `DIV` must be ≥ 16.
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, ≥ 2.
- `CLK` input 1: system clock, rising edge.
- `RST` input 1: reset, asynchronous, active-low.
- `RXD` input 1: serial line, asynchronous to `CLK`, idle high.
- `DATA` output `DATA_BITS`: head-of-FIFO word.
- `PERR` output 1: parity error of the head word. Always 0 when `PARITY = 0`.
- `FERR` output 1: framing error of the head word (any stop bit sampled low).
- `VALID` output 1: FIFO not empty; `DATA`, `PERR` and `FERR` are meaningful.
- `READY` input 1: consumer accepts the head word.
- `OVERRUN` output 1: one-cycle pulse when a completed word is dropped because the FIFO is full.
- `BUSY` output 1: high whenever the FSM is not in `IDLE`.

## Operation
- **Input synchroniser.** `RXD` passes through two flops; both reset to 1. All logic uses the synchronised `rxs`.
- **Majority sampling.** A bit's value is the majority of `rxs` at counter values `DIV/2-1`, `DIV/2` and `DIV/2+1`. The bit decision takes effect at count `DIV/2+1`.
- **Counters.** Baud counter is `$clog2(DIV)` bits and counts 0..`DIV-1`, then wraps to 0. Bit counter is `$clog2(DATA_BITS+1)` bits.
- **State machine:**
  - `IDLE`: when `rxs` = 0, counter ← 0 and go to `START`.
  - `START`: at the majority decision, value 1 is a false start → `IDLE`, nothing is pushed. Value 0 → `DATA` when the counter wraps.
  - `DATA`: shift each decided bit in LSB first. After bit `DATA_BITS-1`, go to `PARITY` if `PARITY != 0`, else to `STOP`.
  - `PARITY`: `PERR` = the XOR of data bits and the parity bit is 0 for odd parity or 1 for even parity. Then go to `STOP`.
  - `STOP`: decide each stop bit. A low stop bit sets `FERR`. At the decision point of the last stop bit, push `{FERR, PERR, data}` into the FIFO. Then go to `IDLE` if `rxs` = 1, else to `WAIT_HIGH`.
  - `WAIT_HIGH`: stay until `rxs` = 1, then → `IDLE`. This prevents a break condition from retriggering as back-to-back frames.
- **FIFO rules:**
  - Pop happens when `VALID && READY`.
  - Push while full: the word is dropped and `OVERRUN` pulses the same cycle.
  - Push and pop in the same cycle while full: the pop is performed first and the push succeeds, so no overrun.
  - Push and pop in the same cycle while empty: the word appears the cycle after the push (no bypass).
- **Reset.** `RST` low at any time, including mid-frame, forces:
  - FSM to `IDLE`;
  - counters, FIFO pointers and FIFO count to 0;
  - synchroniser flops to 1.
  
  A partial frame is discarded. Reset values of outputs: `DATA` = 0, `PERR` = 0, `FERR` = 0, `VALID` = 0, `OVERRUN` = 0, `BUSY` = 0.

## Timing
- From a falling `RXD` edge to `START` entry: 2–3 `CLK` cycles (synchroniser plus idle detect).
- Push occurs at count `DIV/2+1` of the last stop bit. `VALID` rises on the next `CLK` edge.
- Total frame latency from the start-bit edge to `VALID` rises is approximately `(1 + DATA_BITS + (PARITY?1:0) + STOP_BITS - 0.5) × DIV` cycles, plus up to 4 cycles.
- The receiver re-arms half a bit early, inside the stop bit, so it tolerates a transmitter clock up to about 2 % fast.
- `DATA`, `PERR` and `FERR` hold while `VALID && !READY`, and change only on the cycle after a pop.
- Continuous frames at full rate with `READY` held high never overrun.

## Structure
- Package `serial_pkg`:
  - parity constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - FSM state typedef (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`, `WAIT_HIGH`);
  - function `div_of(clk, baud)`.
- Sub-module `serial_fifo`:
  - synchronous FIFO, width `DATA_BITS+2`, depth `FIFO_DEPTH`;
  - same `CLK` and `RST` convention;
  - outputs `full`, `empty`, `dout`; inputs `push`, `pop`.
- The receiver FSM, synchroniser and majority vote live in the top module.

## Test plan
- **8N1 single frame:** defaults, send 0x55 then 0xA3 with `READY` = 1 → two words 0x55 then 0xA3, `PERR` = `FERR` = 0, `OVERRUN` never pulses.
- **Even parity, correct and bad:** `PARITY` = 2, `DATA_BITS` = 7.
  - Send 0x41 with parity bit 0 → `DATA` = 0x41, `PERR` = 0.
  - Resend with parity bit 1 → `PERR` = 1.
- **Glitch rejection:** `RXD` low for 40 cycles, then high → no push, `BUSY` returns to 0 within `DIV` cycles.
  - Single-cycle spike at the centre of a data bit of 0xFF → still decoded as 0xFF.
- **Overrun:** `FIFO_DEPTH` = 4, `READY` = 0, send 5 frames 0x01..0x05.
  - → `OVERRUN` pulses once, at the 5th push.
  - Draining then yields 0x01..0x04.
- **Break:** hold `RXD` low for 3 frame times → exactly one word, `DATA` = 0, `FERR` = 1.
  - No further words until `RXD` goes high and a new start bit arrives.
- **Reset mid-frame:** assert `RST` low asynchronously during bit 3 of 0x7E.
  - → outputs go to reset values immediately, the partial word is not pushed.
  - The next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants, FSM state type and baud divisor helper for the serial receiver.
package serial_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    function automatic int div_of(input int clk_hz, input int baud_hz);
        return clk_hz / baud_hz;
    endfunction

endpackage

// File: rtl/serial_fifo.sv
// Small synchronous FIFO; on a push while full, a pop in the same cycle frees the slot first.
module serial_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    // Head reads as zero when empty so the outputs have a defined reset value.
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/serial_rx_fifo_ctl.sv
// UART receiver with synchroniser, 3-sample majority vote, parity/framing flags
// and an output FIFO with valid/ready handshake.
module serial_rx_fifo_ctl
    import serial_pkg::*;
#(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RXD,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 PERR,
    output logic                 FERR,
    output logic                 VALID,
    input  logic                 READY,
    output logic                 OVERRUN,
    output logic                 BUSY
);
    localparam int DIV  = div_of(CLK_FREQ, BAUD);
    localparam int CW   = $clog2(DIV);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int HALF = DIV / 2;

    localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
    localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    rx_state_t            state_reg;
    logic                 sync_meta_reg;
    logic                 rxs_reg;
    logic [CW-1:0]        cnt_reg;
    logic [BW-1:0]        bit_cnt_reg;
    logic                 smp0_reg;
    logic                 smp1_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 perr_reg;
    logic                 ferr_reg;

    logic                 bit_val;
    logic                 at_dec;
    logic                 at_wrap;
    logic                 last_stop;
    logic                 ferr_new;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS+1:0] fifo_din;
    logic [DATA_BITS+1:0] fifo_dout;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_meta_reg <= 1'b1;
            rxs_reg       <= 1'b1;
        end else begin
            sync_meta_reg <= RXD;
            rxs_reg       <= sync_meta_reg;
        end
    end

    // The third vote is the live sample taken on the decision cycle itself.
    assign bit_val   = (smp0_reg & smp1_reg) | (smp0_reg & rxs_reg) | (smp1_reg & rxs_reg);
    assign at_dec    = (cnt_reg == CNT_DEC);
    assign at_wrap   = (cnt_reg == CNT_LAST);
    assign last_stop = (bit_cnt_reg == BW'(STOP_BITS - 1));
    assign ferr_new  = ferr_reg | ~bit_val;
    assign push      = (state_reg == ST_STOP) && at_dec && last_stop;
    assign fifo_din  = {ferr_new, perr_reg, shift_reg};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            smp0_reg    <= 1'b1;
            smp1_reg    <= 1'b1;
            shift_reg   <= '0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            cnt_reg <= at_wrap ? '0 : cnt_reg + 1'b1;
            if (cnt_reg == CNT_S0)
                smp0_reg <= rxs_reg;
            if (cnt_reg == CNT_S1)
                smp1_reg <= rxs_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (!rxs_reg) begin
                        cnt_reg     <= '0;
                        bit_cnt_reg <= '0;
                        perr_reg    <= 1'b0;
                        ferr_reg    <= 1'b0;
                        state_reg   <= ST_START;
                    end
                end
                ST_START: begin
                    if (at_dec && bit_val)
                        state_reg <= ST_IDLE;
                    else if (at_wrap)
                        state_reg <= ST_DATA;
                end
                ST_DATA: begin
                    if (at_dec) begin
                        shift_reg   <= {bit_val, shift_reg[DATA_BITS-1:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                    if (at_wrap && bit_cnt_reg == BW'(DATA_BITS)) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (at_dec)
                        perr_reg <= (^shift_reg) ^ bit_val ^ (PARITY == PAR_ODD);
                    if (at_wrap)
                        state_reg <= ST_STOP;
                end
                ST_STOP: begin
                    // Leave at mid-stop so a slightly fast transmitter is still caught.
                    if (at_dec) begin
                        ferr_reg <= ferr_new;
                        if (last_stop)
                            state_reg <= rxs_reg ? ST_IDLE : ST_WAIT_HIGH;
                        else
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxs_reg)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign pop     = VALID && READY;
    assign OVERRUN = push && fifo_full && !pop;
    assign VALID   = !fifo_empty;
    assign BUSY    = (state_reg != ST_IDLE);
    assign {FERR, PERR, DATA} = fifo_dout;

    serial_fifo #(
        .WIDTH(DATA_BITS + 2),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .CLK  (CLK),
        .RST  (RST),
        .push (push),
        .pop  (pop),
        .din  (fifo_din),
        .full (fifo_full),
        .empty(fifo_empty),
        .dout (fifo_dout)
    );

endmodule

// File: tb/tb_serial_rx_fifo_ctl.sv
// Bench for serial_rx_fifo_ctl: an 8N1 instance (DIV 100) and a 7E1 instance (DIV 16).
module tb_serial_rx_fifo_ctl;

    localparam int DIV_A = 100;
    localparam int DIV_B = 16;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [8:0] data;
    } word_t;

    typedef struct {
        logic [6:0] data;
        logic       pbit;
        logic       stopb;
        logic [6:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       rxd_a, rxd_b;
    logic       ready_a, ready_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       perr_a, ferr_a, valid_a, overrun_a, busy_a;
    logic       perr_b, ferr_b, valid_b, overrun_b, busy_b;

    int    checks = 0;
    int    errors = 0;
    word_t got_a [512];
    word_t got_b [512];
    int    n_a = 0;
    int    n_b = 0;
    int    ovr_a = 0;
    int    ovr_b = 0;

    serial_rx_fifo_ctl #(
        .CLK_FREQ(10_000_000), .BAUD(100_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .CLK(clk), .RST(rst_n), .RXD(rxd_a), .DATA(data_a), .PERR(perr_a),
        .FERR(ferr_a), .VALID(valid_a), .READY(ready_a), .OVERRUN(overrun_a), .BUSY(busy_a)
    );

    serial_rx_fifo_ctl #(
        .CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_b (
        .CLK(clk), .RST(rst_n), .RXD(rxd_b), .DATA(data_b), .PERR(perr_b),
        .FERR(ferr_b), .VALID(valid_b), .READY(ready_b), .OVERRUN(overrun_b), .BUSY(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer-side monitor: one record per accepted word, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && valid_a && ready_a && n_a < 512) begin
            got_a[n_a] = {ferr_a, perr_a, 1'b0, data_a};
            n_a++;
        end
        if (rst_n && valid_b && ready_b && n_b < 512) begin
            got_b[n_b] = {ferr_b, perr_b, 2'b00, data_b};
            n_b++;
        end
        if (rst_n && overrun_a) ovr_a++;
        if (rst_n && overrun_b) ovr_b++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive frame bits LSB first, one bit per divisor period; optional one-cycle spike.
    task automatic drive(input bit sel_b, input logic [15:0] bits, input int nbits,
                         input int spike, input int stop_after);
        int dv;
        logic [15:0] b;
        dv = sel_b ? DIV_B : DIV_A;
        b  = bits;
        for (int c = 0; c < nbits * dv && c < stop_after; c++) begin
            if (sel_b) rxd_b = b[c / dv] ^ (c == spike);
            else       rxd_a = b[c / dv] ^ (c == spike);
            step(1);
        end
    endtask

    task automatic frame_a(input logic [7:0] d, input logic stopb);
        drive(1'b0, {6'b0, stopb, d, 1'b0}, 10, -1, 1 << 30);
        rxd_a = 1'b1;
    endtask

    task automatic frame_b(input logic [6:0] d, input logic pbit, input logic stopb);
        drive(1'b1, {6'b0, stopb, pbit, d, 1'b0}, 10, -1, 1 << 30);
        rxd_b = 1'b1;
    endtask

    task automatic wait_words(input bit sel_b, input int target, input string name);
        int k;
        k = 0;
        while ((sel_b ? n_b : n_a) < target && k < 3000) begin
            step(1);
            k++;
        end
        chk(name, sel_b ? n_b : n_a, target);
    endtask

    initial begin
        vec_t  vecs [6];
        word_t exp_q [$];
        word_t w;
        int    base, obase, k;
        logic [7:0] rd;
        logic [6:0] rb;
        logic       rp, rs;

        vecs[0] = '{7'h41, 1'b0, 1'b1, 7'h41, 1'b0, 1'b0};
        vecs[1] = '{7'h41, 1'b1, 1'b1, 7'h41, 1'b1, 1'b0};
        vecs[2] = '{7'h7F, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0};
        vecs[3] = '{7'h2A, 1'b0, 1'b1, 7'h2A, 1'b1, 1'b0};
        vecs[4] = '{7'h00, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1};
        vecs[5] = '{7'h55, 1'b0, 1'b1, 7'h55, 1'b0, 1'b0};

        rst_n = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        #2 rst_n = 1'b0;
        step(3);
        chk("reset_a_valid", valid_a, 0);
        chk("reset_a_data", data_a, 0);
        chk("reset_a_flags", {perr_a, ferr_a, overrun_a, busy_a}, 0);
        chk("reset_b_valid", valid_b, 0);
        chk("reset_b_flags", {data_b, perr_b, ferr_b, overrun_b, busy_b}, 0);
        rst_n = 1'b1;
        step(5);

        // 8N1 two frames back to back
        ready_a = 1'b1;
        obase = ovr_a;
        frame_a(8'h55, 1'b1);
        frame_a(8'hA3, 1'b1);
        wait_words(1'b0, 2, "8n1_count");
        chk("8n1_w0", got_a[0], {2'b00, 9'h055});
        chk("8n1_w1", got_a[1], {2'b00, 9'h0A3});
        chk("8n1_no_overrun", ovr_a - obase, 0);

        // 7E1 vector table
        ready_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            base = n_b;
            frame_b(vecs[i].data, vecs[i].pbit, vecs[i].stopb);
            step(2 * DIV_B);
            wait_words(1'b1, base + 1, $sformatf("par_v%0d_count", i));
            chk($sformatf("par_v%0d_word", i), got_b[base],
                {vecs[i].exp_ferr, vecs[i].exp_perr, 2'b00, vecs[i].exp_data});
        end

        // Short low pulse is a false start
        base = n_a;
        rxd_a = 1'b0;
        step(10);
        chk("glitch_busy_high", busy_a, 1);
        step(30);
        rxd_a = 1'b1;
        k = 0;
        while (busy_a && k < DIV_A) begin step(1); k++; end
        chk("glitch_busy_low", busy_a, 0);
        step(2 * DIV_A);
        chk("glitch_no_push", n_a - base, 0);

        // One-cycle spike at the centre of data bit 3
        base = n_a;
        drive(1'b0, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, 4 * DIV_A + DIV_A / 2, 1 << 30);
        wait_words(1'b0, base + 1, "spike_count");
        chk("spike_word", got_a[base], {2'b00, 9'h0FF});

        // Overrun with READY low
        ready_a = 1'b0;
        obase = ovr_a;
        base = n_a;
        for (int i = 1; i <= 5; i++) begin
            frame_a(8'(i), 1'b1);
            if (i == 4) chk("ovr_none_at_4", ovr_a - obase, 0);
        end
        step(5);
        chk("ovr_once_at_5", ovr_a - obase, 1);
        chk("ovr_hold_head", {valid_a, data_a}, {1'b1, 8'h01});
        ready_a = 1'b1;
        wait_words(1'b0, base + 4, "ovr_drain_count");
        step(DIV_A);
        chk("ovr_drain_exact", n_a - base, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("ovr_drain_w%0d", i), got_a[base + i], {2'b00, 9'(i + 1)});
        chk("ovr_total", ovr_a - obase, 1);

        // Break: line low for three frame times
        base = n_a;
        rxd_a = 1'b0;
        step(30 * DIV_A);
        chk("break_one_word", n_a - base, 1);
        chk("break_word", got_a[base], {2'b10, 9'h000});
        chk("break_busy", busy_a, 1);
        rxd_a = 1'b1;
        step(3 * DIV_A);
        chk("break_no_more", n_a - base, 1);
        frame_a(8'h5A, 1'b1);
        wait_words(1'b0, base + 2, "break_recover_count");
        chk("break_recover_word", got_a[base + 1], {2'b00, 9'h05A});

        // Asynchronous reset during bit 3 of 0x7E
        ready_a = 1'b0;
        frame_a(8'h11, 1'b1);
        step(10);
        chk("rst_pre_valid", valid_a, 1);
        drive(1'b0, {6'b0, 1'b1, 8'h7E, 1'b0}, 10, -1, 4 * DIV_A + DIV_A / 2);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", valid_a, 0);
        chk("rst_mid_data", data_a, 0);
        chk("rst_mid_flags", {perr_a, ferr_a, overrun_a, busy_a}, 0);
        rxd_a = 1'b1;
        step(3);
        rst_n = 1'b1;
        base = n_a;
        ready_a = 1'b1;
        step(2 * DIV_A);
        chk("rst_nothing_pushed", n_a - base, 0);
        frame_a(8'h7E, 1'b1);
        wait_words(1'b0, base + 1, "rst_next_count");
        chk("rst_next_word", got_a[base], {2'b00, 9'h07E});

        // Random 8N1 frames against the reference queue
        exp_q.delete();
        obase = ovr_a;
        base = n_a;
        for (int i = 0; i < 20; i++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 5) != 0);
            exp_q.push_back({~rs, 1'b0, 1'b0, rd});
            frame_a(rd, rs);
            step(rs ? $urandom_range(0, 20) : 20 + $urandom_range(0, 20));
        end
        wait_words(1'b0, base + 20, "rand_a_count");
        for (int i = 0; i < 20; i++) begin
            w = exp_q.pop_front();
            chk($sformatf("rand_a_w%0d", i), got_a[base + i], w);
        end
        chk("rand_a_no_overrun", ovr_a - obase, 0);

        // Random 7E1 frames: PERR when the total count of ones is odd
        exp_q.delete();
        base = n_b;
        for (int i = 0; i < 20; i++) begin
            rb = 7'($urandom_range(0, 127));
            rp = 1'($urandom_range(0, 1));
            exp_q.push_back({1'b0, ($countones(rb) + int'(rp)) % 2 == 1, 2'b00, rb});
            frame_b(rb, rp, 1'b1);
            step($urandom_range(0, 5));
        end
        wait_words(1'b1, base + 20, "rand_b_count");
        for (int i = 0; i < 20; i++) begin
            w = exp_q.pop_front();
            chk($sformatf("rand_b_w%0d", i), got_b[base + i], w);
        end
        chk("b_no_overrun", ovr_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
